// File: rtl/mem_sky130_pkg.sv
// Shared constants, types and helpers for the banked sky130 SRAM subsystem.
//
// Contents:
//   MACRO_WIDTH / MACRO_DEPTH / MACRO_ADDR_BIT : geometry of one 32x128 macro
//   IDATA_WIDTH / MAC_MULT_NUM                 : datapath sizing behind the default word width
//   mem_init_state_e                           : zero-fill FSM states
//   lanes(width)                               : number of 32-bit lanes needed for a word
package mem_sky130_pkg;

  localparam int MACRO_WIDTH    = 32;
  localparam int MACRO_DEPTH    = 128;
  localparam int MACRO_ADDR_BIT = 8;

  localparam int IDATA_WIDTH  = 8;
  localparam int MAC_MULT_NUM = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } mem_init_state_e;

  // Ceiling divide of a word width by the macro width.
  function automatic int lanes(input int width);
    return (width + MACRO_WIDTH - 1) / MACRO_WIDTH;
  endfunction

endpackage

// File: rtl/mem_sky130_tile.sv
// One row of NUM_LANES 32x128 macros sharing an address, each lane with its own
// chip select and write enable. Data buses are padded to NUM_LANES*32 bits.
//
// Build switch MEM_SKY130_BEHAV_EN:
//   defined   : each macro is a behavioural 32x128 register array with the same
//               port timing (write on the edge, dout valid the cycle after a read)
//   undefined : sky130_sram_0kbytes_1rw_32x128_32 hard macros are instantiated
//
// Ports:
//   i_clk  : clock
//   i_csb  : per-lane active-low chip select
//   i_web  : per-lane active-low write enable
//   i_addr : 7-bit row address (macro addr0 MSB is tied 0 here)
//   i_din  : padded write data, lane b at bits [b*32 +: 32]
//   o_dout : padded read data, same lane layout
module mem_sky130_tile
  import mem_sky130_pkg::*;
#(
  parameter  int NUM_LANES = 1,
  localparam int PAD_BIT   = NUM_LANES * MACRO_WIDTH
) (
  input  logic                        i_clk,
  input  logic [NUM_LANES-1:0]        i_csb,
  input  logic [NUM_LANES-1:0]        i_web,
  input  logic [MACRO_ADDR_BIT-2:0]   i_addr,
  input  logic [PAD_BIT-1:0]          i_din,
  output logic [PAD_BIT-1:0]          o_dout
);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
`ifdef MEM_SKY130_BEHAV_EN
    logic [MACRO_WIDTH-1:0] r_mem [MACRO_DEPTH];
    logic [MACRO_WIDTH-1:0] r_dout;

    always_ff @(posedge i_clk) begin
      if (!i_csb[g]) begin
        if (!i_web[g]) r_mem[i_addr] <= i_din[g*MACRO_WIDTH +: MACRO_WIDTH];
        else           r_dout        <= r_mem[i_addr];
      end
    end

    assign o_dout[g*MACRO_WIDTH +: MACRO_WIDTH] = r_dout;
`else
    logic [MACRO_ADDR_BIT-1:0] w_addr;
    assign w_addr = {1'b0, i_addr};

    sky130_sram_0kbytes_1rw_32x128_32 u_macro (
      .clk0   (i_clk),
      .csb0   (i_csb[g]),
      .web0   (i_web[g]),
      .wmask0 (4'hF),
      .addr0  (w_addr),
      .din0   (i_din[g*MACRO_WIDTH +: MACRO_WIDTH]),
      .dout0  (o_dout[g*MACRO_WIDTH +: MACRO_WIDTH])
    );
`endif
  end

endmodule

// File: rtl/sky130_sram_0kbytes_1rw_32x128_32.sv
// Functional model of the OpenRAM sky130 32x128 single-port macro. Synthesis
// flows use the hard macro views instead and leave this file out of the list.
//
// Ports:
//   clk0   : clock, rising edge
//   csb0   : active-low chip select
//   web0   : active-low write enable (1 = read)
//   wmask0 : per-byte write mask
//   addr0  : 8-bit address; only rows 0..127 exist, MSB must be 0
//   din0   : write data
//   dout0  : registered read data, valid the cycle after a read access
module sky130_sram_0kbytes_1rw_32x128_32 (
  input  logic        clk0,
  input  logic        csb0,
  input  logic        web0,
  input  logic [3:0]  wmask0,
  input  logic [7:0]  addr0,
  input  logic [31:0] din0,
  output logic [31:0] dout0
);

  logic [31:0] r_mem [128];

  // Accesses with addr0[7] set fall outside the 128 physical rows and are ignored.
  always_ff @(posedge clk0) begin
    if (!csb0 && !addr0[7]) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++) begin
          if (wmask0[i]) r_mem[addr0[6:0]][i*8 +: 8] <= din0[i*8 +: 8];
        end
      end else begin
        dout0 <= r_mem[addr0[6:0]];
      end
    end
  end

endmodule

// File: rtl/mem_banked_sky130.sv
// Single-port SRAM subsystem tiled from 32x128 sky130 macros: NUM_TILES rows of
// NUM_LANES macros. Provides a valid/ready request port with per-lane write
// masking, a fixed two-cycle read pipeline, out-of-range detection and an
// optional zero-fill sweep after reset.
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready.
// req_ready is high every cycle in RUN and low during reset and zero-fill.
// Responses have no backpressure: rsp_valid is a one-cycle pulse two cycles
// after acceptance of a read; rsp_err pulses at the same point for any
// out-of-range request (with rsp_valid only for reads).
//
// Build switch MEM_SKY130_BEHAV_EN (handled in mem_sky130_tile) selects
// behavioural arrays instead of hard macros.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid/ready : request handshake
//   req_wen         : 1 = write, 0 = read
//   req_addr        : word address
//   req_lane_mask   : per-32-bit-lane write enable (ignored for reads)
//   req_wdata       : write data
//   rsp_valid       : read data valid pulse
//   rsp_rdata       : read data, held between responses
//   rsp_err         : out-of-range pulse
//   init_done       : zero-fill complete
//   o_dbg_state     : zero-fill FSM state
module mem_banked_sky130
  import mem_sky130_pkg::*;
#(
  parameter  int DATA_BIT  = IDATA_WIDTH * MAC_MULT_NUM,
  parameter  int DEPTH     = 128,
  parameter  int ADDR_BIT  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter  int INIT_ZERO = 1,
  localparam int NUM_LANES = lanes(DATA_BIT),
  localparam int NUM_TILES = (DEPTH + MACRO_DEPTH - 1) / MACRO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wen,
  input  logic [ADDR_BIT-1:0]  req_addr,
  input  logic [NUM_LANES-1:0] req_lane_mask,
  input  logic [DATA_BIT-1:0]  req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BIT-1:0]  rsp_rdata,
  output logic                 rsp_err,
  output logic                 init_done,
  output mem_init_state_e      o_dbg_state
);

  localparam int LOCAL_BIT = MACRO_ADDR_BIT - 1;
  localparam int PAD_BIT   = NUM_LANES * MACRO_WIDTH;
  localparam int EXT_BIT   = (ADDR_BIT > LOCAL_BIT) ? ADDR_BIT : LOCAL_BIT;
  localparam int TILE_BIT  = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;

  // ---------------- zero-fill FSM ----------------
  mem_init_state_e        r_state;
  mem_init_state_e        w_state_next;
  logic [LOCAL_BIT-1:0]   r_init_cnt;
  logic                   r_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= (INIT_ZERO != 0) ? INIT : RUN;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // Registered so req_ready stays low while reset is asserted even when
      // the FSM resets straight into RUN.
      r_ready <= (w_state_next == RUN);
      if (r_state == INIT) r_init_cnt <= r_init_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      INIT:    if (r_init_cnt == '1) w_state_next = RUN;
      RUN:     w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign req_ready   = r_ready;
  assign init_done   = (r_state == RUN);
  assign o_dbg_state = r_state;

  // ---------------- request decode ----------------
  logic [EXT_BIT-1:0]   w_addr_ext;
  logic [LOCAL_BIT-1:0] w_local_addr;
  logic [EXT_BIT-1:0]   w_tile_idx;
  logic                 w_oor;
  logic                 w_accept;
  logic                 w_wr_go;
  logic                 w_rd_go;

  assign w_addr_ext   = EXT_BIT'(req_addr);
  assign w_local_addr = w_addr_ext[LOCAL_BIT-1:0];
  assign w_tile_idx   = w_addr_ext >> LOCAL_BIT;
  assign w_oor        = (64'(w_addr_ext) >= 64'(DEPTH));
  assign w_accept     = req_valid & r_ready;
  assign w_wr_go      = w_accept &  req_wen & ~w_oor;
  assign w_rd_go      = w_accept & ~req_wen & ~w_oor;

  // ---------------- macro control ----------------
  logic [NUM_LANES-1:0] w_csb [NUM_TILES];
  logic [NUM_LANES-1:0] w_web [NUM_TILES];
  logic [LOCAL_BIT-1:0] w_macro_addr;
  logic [PAD_BIT-1:0]   w_macro_din;

  always_comb begin
    // Zero-extension puts 0 into the padded bits of the top lane.
    w_macro_addr = w_local_addr;
    w_macro_din  = PAD_BIT'(req_wdata);
    if (r_state == INIT) begin
      w_macro_addr = r_init_cnt;
      w_macro_din  = '0;
    end
    for (int t = 0; t < NUM_TILES; t++) begin
      w_csb[t] = '1;
      w_web[t] = '1;
      if (r_state == INIT) begin
        w_csb[t] = '0;
        w_web[t] = '0;
      end else if (w_tile_idx == EXT_BIT'(t)) begin
        if (w_wr_go) begin
          w_csb[t] = ~req_lane_mask;
          w_web[t] = '0;
        end else if (w_rd_go) begin
          w_csb[t] = '0;
        end
      end
    end
  end

  logic [PAD_BIT-1:0] w_dout [NUM_TILES];

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    mem_sky130_tile #(
      .NUM_LANES (NUM_LANES)
    ) u_tile (
      .i_clk  (clk),
      .i_csb  (w_csb[t]),
      .i_web  (w_web[t]),
      .i_addr (w_macro_addr),
      .i_din  (w_macro_din),
      .o_dout (w_dout[t])
    );
  end

  // ---------------- read pipeline ----------------
  // Stage 1 is captured on the same edge as the macro access, so the output
  // mux below follows the tile that was actually read, not the live address.
  logic                r_s1_rd;
  logic                r_s1_err;
  logic [TILE_BIT-1:0] r_s1_tile;
  logic                r_rsp_valid;
  logic                r_rsp_err;
  logic [DATA_BIT-1:0] r_rsp_rdata;
  logic [PAD_BIT-1:0]  w_rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_rd   <= 1'b0;
      r_s1_err  <= 1'b0;
      r_s1_tile <= '0;
    end else begin
      r_s1_rd  <= w_accept & ~req_wen;
      r_s1_err <= w_accept & w_oor;
      if (w_rd_go) r_s1_tile <= TILE_BIT'(w_tile_idx);
    end
  end

  always_comb begin
    w_rd_mux = '0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (r_s1_tile == TILE_BIT'(t)) w_rd_mux = w_dout[t];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= r_s1_rd;
      r_rsp_err   <= r_s1_err;
      // Out-of-range reads never touched a macro; return zeros instead.
      if (r_s1_rd) r_rsp_rdata <= r_s1_err ? '0 : w_rd_mux[DATA_BIT-1:0];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
